// File: rtl/canny_pkg.sv
// Shared encodings for the Canny window host: op modes, engine register selects,
// host state enum and the plane-sequencing helper.
package canny_pkg;

  localparam int DATA_W     = 8;
  localparam int WIN_PIXELS = 25;

  localparam logic [1:0] MODE_GAUSSIAN   = 2'd0;
  localparam logic [1:0] MODE_SOBEL      = 2'd1;
  localparam logic [1:0] MODE_NMS        = 2'd2;
  localparam logic [1:0] MODE_HYSTERESIS = 2'd3;

  localparam logic [3:0] REG_GAUSSIAN   = 4'd0;
  localparam logic [3:0] REG_SOBEL_X    = 4'd1;
  localparam logic [3:0] REG_SOBEL_Y    = 4'd2;
  localparam logic [3:0] REG_NMS        = 4'd3;
  localparam logic [3:0] REG_HYSTERESIS = 4'd4;

  localparam logic [3:0] WRITE_REGX = 4'd0;
  localparam logic [3:0] WRITE_REGY = 4'd1;
  localparam logic [3:0] WRITE_REGZ = 4'd2;

  localparam logic [1:0] PLANE_NONE = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_OP,
    ST_RD,
    ST_CAP,
    ST_OUT
  } host_state_t;

  // Lowest enabled plane at or above 'from'; PLANE_NONE when nothing is left to load.
  function automatic logic [1:0] first_plane(input logic [2:0] planes, input logic [1:0] from);
    logic [1:0] p;
    p = PLANE_NONE;
    for (int i = 2; i >= 0; i--) begin
      if (i >= int'(from) && planes[i]) p = 2'(i);
    end
    return p;
  endfunction

endpackage

// File: rtl/canny_addr_gen.sv
// Window index counter 0..24 kept as row/col pair, with a wrap pulse on the last pixel.
module canny_addr_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [2:0] row,
  output logic [2:0] col,
  output logic       wrap
);

  logic [2:0] row_reg;
  logic [2:0] col_reg;

  assign row  = row_reg;
  assign col  = col_reg;
  assign wrap = en && (row_reg == 3'd4) && (col_reg == 3'd4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_reg <= 3'd0;
      col_reg <= 3'd0;
    end else if (clr) begin
      row_reg <= 3'd0;
      col_reg <= 3'd0;
    end else if (en) begin
      if (col_reg == 3'd4) begin
        col_reg <= 3'd0;
        row_reg <= (row_reg == 3'd4) ? 3'd0 : row_reg + 3'd1;
      end else begin
        col_reg <= col_reg + 3'd1;
      end
    end
  end

endmodule

// File: rtl/canny_window_host.sv
// Bus initiator for the Canny engine: loads 5x5 planes, pulses the op, reads results back.
// Optional perf counters (perf_windows, perf_stall) are built when CANNY_HOST_PERF_EN is defined.
module canny_window_host
  import canny_pkg::*;
#(
  parameter int DATA_W    = canny_pkg::DATA_W,
  parameter int GAUSS_CYC = 2,
  parameter int SOBEL_CYC = 4,
  parameter int NMS_CYC   = 2,
  parameter int HYST_CYC  = 2,
  parameter int GUARD_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic [2:0]        cmd_planes,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [DATA_W-1:0] pix_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_last,
  output logic [2:0]        ce_row,
  output logic [2:0]        ce_col,
  output logic              ce_bce,
  output logic              ce_bwe,
  output logic [DATA_W-1:0] ce_indata,
  input  logic [DATA_W-1:0] ce_outdata,
  output logic [2:0]        ce_opmode,
  output logic              ce_bopen,
  output logic [3:0]        ce_readreg,
  output logic [3:0]        ce_writereg
`ifdef CANNY_HOST_PERF_EN
  ,
  output logic [15:0]       perf_windows,
  output logic [15:0]       perf_stall
`endif
);

  host_state_t       state_reg, state_next;
  logic [1:0]        mode_reg;
  logic [2:0]        planes_reg;
  logic [1:0]        plane_reg;
  logic [7:0]        op_cnt_reg;
  logic [7:0]        op_load;
  logic              sobel_second_reg;
  logic [DATA_W-1:0] res_data_reg;

  logic       addr_en;
  logic       addr_clr;
  logic       addr_wrap;
  logic [2:0] addr_row;
  logic [2:0] addr_col;

  assign addr_en  = (state_reg == ST_LOAD) && pix_valid;
  assign addr_clr = (state_reg == ST_IDLE);

  canny_addr_gen u_addr_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (addr_clr),
    .en   (addr_en),
    .row  (addr_row),
    .col  (addr_col),
    .wrap (addr_wrap)
  );

  // Down-counter preload: op length minus one, so OP lasts exactly len cycles.
  always_comb begin
    op_load = 8'd0;
    case (cmd_mode)
      MODE_GAUSSIAN: op_load = 8'(GAUSS_CYC + GUARD_CYC - 1);
      MODE_SOBEL:    op_load = 8'(SOBEL_CYC + GUARD_CYC - 1);
      MODE_NMS:      op_load = 8'(NMS_CYC + GUARD_CYC - 1);
      default:       op_load = 8'(HYST_CYC + GUARD_CYC - 1);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_next = (first_plane(cmd_planes, 2'd0) == PLANE_NONE) ? ST_OP : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (addr_wrap && first_plane(planes_reg, plane_reg + 2'd1) == PLANE_NONE) begin
          state_next = ST_OP;
        end
      end
      ST_OP:  if (op_cnt_reg == 8'd0) state_next = ST_RD;
      ST_RD:  state_next = ST_CAP;
      ST_CAP: state_next = ST_OUT;
      ST_OUT: begin
        if (res_ready) begin
          state_next = (mode_reg == MODE_SOBEL && !sobel_second_reg) ? ST_RD : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg         <= 2'd0;
      planes_reg       <= 3'd0;
      plane_reg        <= 2'd0;
      op_cnt_reg       <= 8'd0;
      sobel_second_reg <= 1'b0;
      res_data_reg     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            mode_reg         <= cmd_mode;
            planes_reg       <= cmd_planes;
            plane_reg        <= first_plane(cmd_planes, 2'd0);
            op_cnt_reg       <= op_load;
            sobel_second_reg <= 1'b0;
          end
        end
        ST_LOAD: if (addr_wrap) plane_reg <= first_plane(planes_reg, plane_reg + 2'd1);
        ST_OP:   op_cnt_reg <= op_cnt_reg - 8'd1;
        ST_CAP:  res_data_reg <= ce_outdata;
        ST_OUT:  if (res_ready && mode_reg == MODE_SOBEL) sobel_second_reg <= 1'b1;
        default: ;
      endcase
    end
  end

  assign res_data = res_data_reg;

  // Write strobe follows pix_valid combinationally so each handshake is its own bus write.
  always_comb begin
    cmd_ready   = 1'b0;
    pix_ready   = 1'b0;
    res_valid   = 1'b0;
    res_last    = 1'b0;
    ce_bce      = 1'b1;
    ce_bwe      = 1'b1;
    ce_bopen    = 1'b1;
    ce_row      = 3'd0;
    ce_col      = 3'd0;
    ce_indata   = '0;
    ce_readreg  = 4'd0;
    ce_writereg = 4'd0;
    ce_opmode   = 3'd0;
    case (state_reg)
      ST_IDLE: cmd_ready = 1'b1;
      ST_LOAD: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          ce_bce      = 1'b0;
          ce_bwe      = 1'b0;
          ce_writereg = {2'b00, plane_reg};
          ce_row      = addr_row;
          ce_col      = addr_col;
          ce_indata   = pix_data;
        end
      end
      ST_OP: begin
        ce_bopen  = 1'b0;
        ce_opmode = {1'b0, mode_reg};
      end
      ST_RD: begin
        ce_bce = 1'b0;
        case (mode_reg)
          MODE_GAUSSIAN: ce_readreg = REG_GAUSSIAN;
          MODE_SOBEL:    ce_readreg = sobel_second_reg ? REG_SOBEL_Y : REG_SOBEL_X;
          MODE_NMS: begin
            ce_readreg = REG_NMS;
            ce_row     = 3'd1;
            ce_col     = 3'd1;
          end
          default:       ce_readreg = REG_HYSTERESIS;
        endcase
      end
      ST_OUT: begin
        res_valid = 1'b1;
        res_last  = (mode_reg != MODE_SOBEL) || sobel_second_reg;
      end
      default: ;
    endcase
  end

`ifdef CANNY_HOST_PERF_EN
  logic [15:0] perf_windows_reg;
  logic [15:0] perf_stall_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_windows_reg <= 16'd0;
      perf_stall_reg   <= 16'd0;
    end else begin
      if (res_valid && res_ready && res_last && perf_windows_reg != 16'hFFFF) begin
        perf_windows_reg <= perf_windows_reg + 16'd1;
      end
      if (state_reg == ST_LOAD && !pix_valid && perf_stall_reg != 16'hFFFF) begin
        perf_stall_reg <= perf_stall_reg + 16'd1;
      end
    end
  end

  assign perf_windows = perf_windows_reg;
  assign perf_stall   = perf_stall_reg;
`endif

endmodule
